// File: rtl/boss_pkg.sv
// ============================================================
// boss_pkg : shared boss types, sprite geometry and jump constants
// Rev 1.0
// ============================================================
`default_nettype none

package boss_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CHASE   = 2'd1,
      ENRAGED = 2'd2,
      DEAD    = 2'd3
   } boss_phase_t;

   localparam int BOSS_HGT    = 95;
   localparam int BOSS_LNG    = 106;
   localparam int SCREEN_W    = 1024;
   localparam int SCREEN_H    = 768;

   localparam int JUMP_PERIOD = 90;
   localparam int JUMP_VY0    = -12;

endpackage

`default_nettype wire

// File: rtl/boss_ctrl_if.sv
// ============================================================
// boss_ctrl_if : game-side bus between player/collision logic and the boss
// Rev 1.0
// ============================================================
`default_nettype none

interface boss_ctrl_if import boss_pkg::*; #(
   parameter int HP_W  = 7,
   parameter int DMG_W = 4
) ();

   logic              game_active;
   logic              hit;
   logic [DMG_W-1:0]  hit_dmg;
   logic [11:0]       char_x;
   logic              frame_tick;
   logic [11:0]       boss_x;
   logic [11:0]       boss_y;
   logic [HP_W-1:0]   boss_hp;
   boss_phase_t       phase;
   logic              defeated;

   modport master (
      output game_active, hit, hit_dmg, char_x,
      input  frame_tick, boss_x, boss_y, boss_hp, phase, defeated
   );

   modport slave (
      input  game_active, hit, hit_dmg, char_x,
      output frame_tick, boss_x, boss_y, boss_hp, phase, defeated
   );

endinterface

`default_nettype wire

// File: rtl/boss_ctrl_frame_tick_gen.sv
// ============================================================
// frame_tick_gen : free-running one-cycle pulse every CLK_HZ/FRAME_HZ cycles
// Rev 1.0
// ============================================================
`default_nettype none

module frame_tick_gen #(
   parameter int CLK_HZ   = 65_000_000,
   parameter int FRAME_HZ = 60
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int DIV   = CLK_HZ / FRAME_HZ;
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic             tick_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         tick_q <= (cnt_q == CNT_LAST);
         cnt_q  <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   assign tick = tick_q;

endmodule

`default_nettype wire

// File: rtl/boss_ctrl.sv
// ============================================================
// boss_ctrl : boss phase FSM, HP/iframes and chase movement
// Rev 1.0 -- optional jump arc when BOSS_JUMP_EN is defined
// ============================================================
`default_nettype none

module boss_ctrl import boss_pkg::*; #(
   parameter int CLK_HZ    = 65_000_000,
   parameter int FRAME_HZ  = 60,
   parameter int HP_W      = 7,
   parameter int MAX_HP    = 100,
   parameter int ENRAGE_HP = 40,
   parameter int DMG_W     = 4,
   parameter int IFRAMES   = 8,
   parameter int SPEED     = 2,
   parameter int DEADZONE  = 4,
   parameter int START_X   = 700,
   parameter int GROUND_Y  = 500,
   parameter int X_MIN     = 0,
   parameter int X_MAX     = 1023
) (
   input  logic     clk,
   input  logic     rst,
   boss_ctrl_if.slave bus
);

   localparam int IF_W = $clog2(IFRAMES + 1);
   localparam logic [HP_W-1:0]  HP_INIT  = HP_W'(MAX_HP);
   localparam logic [HP_W-1:0]  HP_ENR   = HP_W'(ENRAGE_HP);
   localparam logic [IF_W-1:0]  IF_LOAD  = IF_W'(IFRAMES);
   localparam logic [11:0]      X_INIT   = 12'(START_X);
   localparam logic [12:0]      X_LIM13  = 13'(X_MAX - BOSS_LNG);
   localparam logic [11:0]      X_LIM12  = 12'(X_MAX - BOSS_LNG);
   localparam logic [12:0]      X_MIN13  = 13'(X_MIN);
   localparam logic [12:0]      DZ13     = 13'(DEADZONE);

   logic             tick;
   boss_phase_t      phase_q;
   logic [HP_W-1:0]  hp_q;
   logic [HP_W-1:0]  hp_d;
   logic [11:0]      x_q;
   logic [11:0]      x_d;
   logic [IF_W-1:0]  iframe_q;
   logic             defeated_q;
   logic             accept;
   logic             chasing;
   logic [HP_W-1:0]  dmg_ext;
   logic [12:0]      x13;
   logic [12:0]      cx13;
   logic [12:0]      step13;

   frame_tick_gen #(
      .CLK_HZ   (CLK_HZ),
      .FRAME_HZ (FRAME_HZ)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   assign chasing = (phase_q == CHASE) || (phase_q == ENRAGED);
   assign accept  = bus.hit && chasing && (iframe_q == '0);
   assign dmg_ext = HP_W'(bus.hit_dmg);
   assign hp_d    = (hp_q > dmg_ext) ? hp_q - dmg_ext : '0;

   // Widened to 13 bits so the deadzone and step sums cannot wrap near either edge.
   always_comb begin
      x13    = {1'b0, x_q};
      cx13   = {1'b0, bus.char_x};
      step13 = (phase_q == ENRAGED) ? 13'(2 * SPEED) : 13'(SPEED);
      x_d    = x_q;
      if (x13 + DZ13 < cx13) begin
         x_d = (x13 + step13 > X_LIM13) ? X_LIM12 : 12'(x13 + step13);
      end else if (x13 > cx13 + DZ13) begin
         x_d = (x13 < X_MIN13 + step13) ? 12'(X_MIN13) : 12'(x13 - step13);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst || !bus.game_active) begin
         phase_q    <= IDLE;
         defeated_q <= 1'b0;
         hp_q       <= HP_INIT;
         x_q        <= X_INIT;
         iframe_q   <= '0;
      end else begin
         case (phase_q)
            IDLE:    phase_q <= CHASE;
            CHASE: begin
               if (hp_q == '0) begin
                  phase_q    <= DEAD;
                  defeated_q <= 1'b1;
               end else if (hp_q <= HP_ENR) begin
                  phase_q <= ENRAGED;
               end
            end
            ENRAGED: begin
               if (hp_q == '0) begin
                  phase_q    <= DEAD;
                  defeated_q <= 1'b1;
               end
            end
            default: ;
         endcase

         // A fresh hit reloads the window even on a frame tick.
         if (accept) begin
            hp_q     <= hp_d;
            iframe_q <= IF_LOAD;
         end else if (tick && (iframe_q != '0)) begin
            iframe_q <= iframe_q - 1'b1;
         end

         if (tick && chasing) begin
            x_q <= x_d;
         end
      end
   end

`ifdef BOSS_JUMP_EN
   localparam logic [11:0]        Y_GND   = 12'(GROUND_Y);
   localparam logic signed [13:0] Y_GND14 = 14'(GROUND_Y);
   localparam logic signed [5:0]  VY0     = 6'(JUMP_VY0);
   localparam logic [6:0]         JC_LAST = 7'(JUMP_PERIOD - 1);

   logic [11:0]        y_q;
   logic signed [5:0]  vy_q;
   logic [6:0]         jcnt_q;
   logic signed [13:0] y_sum;

   assign y_sum = $signed({2'b00, y_q}) + 14'(vy_q);

   always_ff @(posedge clk) begin
      if (!rst || !bus.game_active) begin
         y_q    <= Y_GND;
         vy_q   <= '0;
         jcnt_q <= '0;
      end else if (tick) begin
         if (phase_q != ENRAGED) begin
            y_q    <= Y_GND;
            vy_q   <= '0;
            jcnt_q <= '0;
         end else if ((y_q == Y_GND) && (vy_q == '0)) begin
            if (jcnt_q == JC_LAST) begin
               vy_q   <= VY0;
               jcnt_q <= '0;
            end else begin
               jcnt_q <= jcnt_q + 1'b1;
            end
         end else if (y_sum >= Y_GND14) begin
            y_q  <= Y_GND;
            vy_q <= '0;
         end else begin
            y_q  <= y_sum[11:0];
            vy_q <= vy_q + 6'sd1;
         end
      end
   end

   assign bus.boss_y = y_q;
`else
   assign bus.boss_y = 12'(GROUND_Y);
`endif

   assign bus.frame_tick = tick;
   assign bus.boss_x     = x_q;
   assign bus.boss_hp    = hp_q;
   assign bus.phase      = phase_q;
   assign bus.defeated   = defeated_q;

endmodule

`default_nettype wire

// File: tb/tb_boss_ctrl.sv
// ============================================================
// tb_boss_ctrl : self-checking bench for boss_ctrl (10-cycle frames)
// Rev 1.0
// ============================================================
`default_nettype none

module tb_boss_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   boss_ctrl_if #(.HP_W(7), .DMG_W(4)) bus ();

   boss_ctrl #(
      .CLK_HZ   (600),
      .FRAME_HZ (60)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: spec rules in plain integer arithmetic.
   int m_rel  = 0;
   int m_tick = 0;
   int m_x    = 700;
   int m_hp   = 100;
   int m_ph   = 0;
   int m_if   = 0;

   always @(posedge clk) begin : ref_model
      int t, ph, hp, x, ifr, s, cx, dmg;
      if (!rst) begin
         m_rel = 0; m_tick = 0; m_x = 700; m_hp = 100; m_ph = 0; m_if = 0;
      end else begin
         t = m_tick; ph = m_ph; hp = m_hp; x = m_x; ifr = m_if;
         cx  = int'(bus.char_x);
         dmg = int'(bus.hit_dmg);
         m_rel  = m_rel + 1;
         m_tick = ((m_rel % 10) == 0) ? 1 : 0;
         if (!bus.game_active) begin
            m_ph = 0; m_hp = 100; m_x = 700; m_if = 0;
         end else begin
            if (ph == 0)                 m_ph = 1;
            else if (ph != 3 && hp == 0) m_ph = 3;
            else if (ph == 1 && hp <= 40) m_ph = 2;
            if (bus.hit && (ph == 1 || ph == 2) && ifr == 0) begin
               m_hp = (hp > dmg) ? hp - dmg : 0;
               m_if = 8;
            end else if (t == 1 && ifr > 0) begin
               m_if = ifr - 1;
            end
            if (t == 1 && (ph == 1 || ph == 2)) begin
               s = (ph == 2) ? 4 : 2;
               if (x + 4 < cx)      m_x = (x + s > 917) ? 917 : x + s;
               else if (x > cx + 4) m_x = (x - s < 0) ? 0 : x - s;
            end
         end
      end
   end

   task automatic pulse_hit(input int d);
      bus.hit     = 1'b1;
      bus.hit_dmg = 4'(d);
      @(negedge clk);
      bus.hit     = 1'b0;
      bus.hit_dmg = 4'd0;
   endtask

   task automatic reinit();
      bus.game_active = 1'b0;
      @(negedge clk);
      bus.game_active = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.game_active = 1'b0; bus.hit = 1'b0; bus.hit_dmg = 4'd0; bus.char_x = 12'd700;
      repeat (3) @(negedge clk);
      n_cmp++; if (bus.frame_tick !== 1'b0) begin n_err++; $display("FAIL reset_tick got %0d want 0", bus.frame_tick); end
      n_cmp++; if (bus.boss_x !== 12'd700) begin n_err++; $display("FAIL reset_x got %0d want 700", bus.boss_x); end
      n_cmp++; if (bus.boss_y !== 12'd500) begin n_err++; $display("FAIL reset_y got %0d want 500", bus.boss_y); end
      n_cmp++; if (bus.boss_hp !== 7'd100) begin n_err++; $display("FAIL reset_hp got %0d want 100", bus.boss_hp); end
      n_cmp++; if (bus.phase !== 2'd0) begin n_err++; $display("FAIL reset_phase got %0d want 0", bus.phase); end
      n_cmp++; if (bus.defeated !== 1'b0) begin n_err++; $display("FAIL reset_defeated got %0d want 0", bus.defeated); end
   endtask

   task automatic test_frame_tick();
      int last = -1;
      rst = 1'b1;
      for (int i = 0; i < 45; i++) begin
         @(negedge clk);
         n_cmp++;
         if (bus.frame_tick !== 1'(m_tick)) begin
            n_err++; $display("FAIL tick_cyc%0d got %0d want %0d", i, bus.frame_tick, m_tick);
         end
         if (bus.frame_tick === 1'b1) begin
            if (last >= 0) begin
               n_cmp++;
               if ((i - last) !== 10) begin n_err++; $display("FAIL tick_period got %0d want 10", i - last); end
            end
            last = i;
         end
      end
      n_cmp++; if (last < 0) begin n_err++; $display("FAIL tick_seen got none want pulses"); end
   endtask

   task automatic test_enrage();
      bus.char_x = 12'd700;
      bus.game_active = 1'b1;
      @(negedge clk);
      n_cmp++; if (bus.phase !== 2'd1) begin n_err++; $display("FAIL enter_chase got %0d want 1", bus.phase); end
      for (int k = 0; k < 4; k++) begin
         if (k > 0) repeat (100) @(negedge clk);
         pulse_hit(15);
         n_cmp++;
         if (bus.boss_hp !== 7'(100 - 15 * (k + 1))) begin
            n_err++; $display("FAIL enrage_hp%0d got %0d want %0d", k, bus.boss_hp, 100 - 15 * (k + 1));
         end
      end
      n_cmp++; if (bus.phase !== 2'd1) begin n_err++; $display("FAIL enrage_lat got %0d want 1", bus.phase); end
      @(negedge clk);
      n_cmp++; if (bus.phase !== 2'd2) begin n_err++; $display("FAIL enrage_phase got %0d want 2", bus.phase); end
   endtask

   task automatic test_iframes();
      reinit();
      pulse_hit(5);
      n_cmp++; if (bus.boss_hp !== 7'd95) begin n_err++; $display("FAIL iframe_first got %0d want 95", bus.boss_hp); end
      repeat (30) @(negedge clk);
      pulse_hit(5);
      n_cmp++; if (bus.boss_hp !== 7'd95) begin n_err++; $display("FAIL iframe_drop got %0d want 95", bus.boss_hp); end
      repeat (58) @(negedge clk);
      pulse_hit(5);
      n_cmp++; if (bus.boss_hp !== 7'd90) begin n_err++; $display("FAIL iframe_expire got %0d want 90", bus.boss_hp); end
   endtask

   task automatic test_saturation();
      int dm [6] = '{15, 15, 15, 15, 15, 12};
      bus.char_x = 12'd0;
      foreach (dm[k]) begin
         repeat (95) @(negedge clk);
         pulse_hit(dm[k]);
      end
      n_cmp++; if (bus.boss_hp !== 7'd3) begin n_err++; $display("FAIL sat_pre got %0d want 3", bus.boss_hp); end
      repeat (95) @(negedge clk);
      pulse_hit(10);
      n_cmp++; if (bus.boss_hp !== 7'd0) begin n_err++; $display("FAIL sat_zero got %0d want 0", bus.boss_hp); end
      @(negedge clk);
      n_cmp++; if (bus.phase !== 2'd3) begin n_err++; $display("FAIL sat_dead got %0d want 3", bus.phase); end
      n_cmp++; if (bus.defeated !== 1'b1) begin n_err++; $display("FAIL sat_defeated got %0d want 1", bus.defeated); end
      repeat (95) @(negedge clk);
      pulse_hit(10);
      n_cmp++; if (bus.boss_hp !== 7'd0) begin n_err++; $display("FAIL sat_hold got %0d want 0", bus.boss_hp); end
      n_cmp++; if (bus.boss_x !== 12'(m_x)) begin n_err++; $display("FAIL sat_x got %0d want %0d", bus.boss_x, m_x); end
      bus.game_active = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.phase !== 2'd0) begin n_err++; $display("FAIL reinit_phase got %0d want 0", bus.phase); end
      n_cmp++; if (bus.boss_hp !== 7'd100) begin n_err++; $display("FAIL reinit_hp got %0d want 100", bus.boss_hp); end
      n_cmp++; if (bus.boss_x !== 12'd700) begin n_err++; $display("FAIL reinit_x got %0d want 700", bus.boss_x); end
      n_cmp++; if (bus.defeated !== 1'b0) begin n_err++; $display("FAIL reinit_defeated got %0d want 0", bus.defeated); end
   endtask

   task automatic test_movement();
      int xa, guard;
      bus.char_x = 12'd100;
      reinit();
      guard = 0;
      while (bus.frame_tick !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
      xa = int'(bus.boss_x);
      repeat (10) @(negedge clk);
      n_cmp++; if ((xa - int'(bus.boss_x)) !== 2) begin n_err++; $display("FAIL chase_step got %0d want 2", xa - int'(bus.boss_x)); end
      for (int i = 0; i < 3200; i++) begin
         @(negedge clk);
         n_cmp++;
         if (bus.boss_x !== 12'(m_x)) begin n_err++; $display("FAIL chase_x cyc%0d got %0d want %0d", i, bus.boss_x, m_x); end
      end
      n_cmp++; if (bus.boss_x !== 12'd104) begin n_err++; $display("FAIL chase_rest got %0d want 104", bus.boss_x); end

      reinit();
      for (int k = 0; k < 4; k++) begin
         repeat (95) @(negedge clk);
         pulse_hit(15);
      end
      @(negedge clk);
      guard = 0;
      while (bus.frame_tick !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
      xa = int'(bus.boss_x);
      repeat (10) @(negedge clk);
      n_cmp++; if ((xa - int'(bus.boss_x)) !== 4) begin n_err++; $display("FAIL enraged_step got %0d want 4", xa - int'(bus.boss_x)); end
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         n_cmp++;
         if (bus.boss_x !== 12'(m_x)) begin n_err++; $display("FAIL enraged_x cyc%0d got %0d want %0d", i, bus.boss_x, m_x); end
      end
      bus.char_x = 12'd1023;
      for (int i = 0; i < 2500; i++) begin
         @(negedge clk);
         n_cmp++;
         if (bus.boss_x !== 12'(m_x)) begin n_err++; $display("FAIL right_x cyc%0d got %0d want %0d", i, bus.boss_x, m_x); end
      end
      n_cmp++; if (bus.boss_x !== 12'd917) begin n_err++; $display("FAIL right_clamp got %0d want 917", bus.boss_x); end
   endtask

   task automatic test_reset_midgame();
      bus.char_x = 12'd700;
      reinit();
      for (int k = 0; k < 4; k++) begin
         repeat (95) @(negedge clk);
         pulse_hit(15);
      end
      @(negedge clk);
      n_cmp++; if (bus.phase !== 2'd2) begin n_err++; $display("FAIL mid_enraged got %0d want 2", bus.phase); end
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      n_cmp++; if (bus.frame_tick !== 1'b0) begin n_err++; $display("FAIL mid_tick got %0d want 0", bus.frame_tick); end
      n_cmp++; if (bus.boss_hp !== 7'd100) begin n_err++; $display("FAIL mid_hp got %0d want 100", bus.boss_hp); end
      n_cmp++; if (bus.phase !== 2'd0) begin n_err++; $display("FAIL mid_phase got %0d want 0", bus.phase); end
      n_cmp++; if (bus.boss_x !== 12'd700) begin n_err++; $display("FAIL mid_x got %0d want 700", bus.boss_x); end
      n_cmp++; if (bus.boss_y !== 12'd500) begin n_err++; $display("FAIL mid_y got %0d want 500", bus.boss_y); end
      n_cmp++; if (bus.defeated !== 1'b0) begin n_err++; $display("FAIL mid_defeated got %0d want 0", bus.defeated); end
      @(negedge clk);
      n_cmp++; if (bus.phase !== 2'd1) begin n_err++; $display("FAIL mid_rechase got %0d want 1", bus.phase); end
      pulse_hit(7);
      n_cmp++; if (bus.boss_hp !== 7'd93) begin n_err++; $display("FAIL mid_hit got %0d want 93", bus.boss_hp); end
   endtask

   task automatic test_random();
      reinit();
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         n_cmp++; if (bus.boss_hp !== 7'(m_hp)) begin n_err++; $display("FAIL rnd_hp cyc%0d got %0d want %0d", i, bus.boss_hp, m_hp); end
         n_cmp++; if (bus.phase !== 2'(m_ph)) begin n_err++; $display("FAIL rnd_phase cyc%0d got %0d want %0d", i, bus.phase, m_ph); end
         n_cmp++; if (bus.boss_x !== 12'(m_x)) begin n_err++; $display("FAIL rnd_x cyc%0d got %0d want %0d", i, bus.boss_x, m_x); end
         n_cmp++; if (bus.frame_tick !== 1'(m_tick)) begin n_err++; $display("FAIL rnd_tick cyc%0d got %0d want %0d", i, bus.frame_tick, m_tick); end
         n_cmp++; if (bus.defeated !== (m_ph == 3)) begin n_err++; $display("FAIL rnd_defeated cyc%0d got %0d want %0d", i, bus.defeated, m_ph == 3); end
         n_cmp++; if (bus.boss_y !== 12'd500) begin n_err++; $display("FAIL rnd_y cyc%0d got %0d want 500", i, bus.boss_y); end
         bus.hit         = !bus.hit && ($urandom_range(0, 7) == 0);
         bus.hit_dmg     = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 49) == 0) bus.char_x = 12'($urandom_range(0, 1023));
         bus.game_active = ($urandom_range(0, 1499) != 0);
      end
      bus.hit = 1'b0;
      bus.game_active = 1'b1;
   endtask

   initial begin
      test_reset();
      test_frame_tick();
      test_enrage();
      test_iframes();
      test_saturation();
      test_movement();
      test_reset_midgame();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/boss_ctrl.md
Name: boss_ctrl

Overview:
Parametrised boss controller. It is the successor to the fixed boss top-level, and owns game-side state only; rendering stays separate.
It contains:
- a configurable frame-tick generator
- a 4-state phase FSM (IDLE/CHASE/ENRAGED/DEAD)
- HP with variable damage and invincibility frames
- phase-dependent chase movement toward the player

It sits between player/collision logic and the boss renderer, and feeds boss position, HP and phase downstream.

Parameters:
CLK_HZ, 65_000_000, system clock frequency
FRAME_HZ, 60, game frame rate
HP_W, 7, HP width
MAX_HP, 100, HP at reset/re-init
ENRAGE_HP, 40, HP at or below which CHASE→ENRAGED
DMG_W, 4, damage input width
IFRAMES, 8, frames of invulnerability after an accepted hit
SPEED, 2, pixels/frame in CHASE (ENRAGED uses 2*SPEED)
DEADZONE, 4, horizontal tolerance before moving
START_X, 700, re-init x
GROUND_Y, 500, re-init / resting y
X_MIN, 0, left clamp
X_MAX, 1023, right screen edge; boss_x clamps to X_MAX-BOSS_LNG

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
game_active  in  1  game running
hit  in  1  one-cycle pulse: player struck boss
hit_dmg  in  DMG_W  damage amount, valid with hit
char_x  in  12  player x
frame_tick  out  1  one-cycle pulse per frame
boss_x  out  12  boss left x
boss_y  out  12  boss top y
boss_hp  out  HP_W  current HP
phase  out  2  boss_phase_t encoding
defeated  out  1  high while in DEAD

Behaviour:
- Reset: sampled at posedge when rst==0.
  - Outputs: frame_tick=0, boss_x=START_X, boss_y=GROUND_Y, boss_hp=MAX_HP, phase=IDLE, defeated=0.
  - Internals: tick counter=0, iframe counter=0.
- Frame tick:
  - Counter runs 0..CLK_HZ/FRAME_HZ-1. frame_tick is registered, high for the single cycle after the counter wraps.
  - Free-running, independent of game_active. Counter width is $clog2(CLK_HZ/FRAME_HZ).
- FSM, evaluated every cycle on registered values (one-cycle latency):
  - IDLE→CHASE when game_active=1.
  - CHASE→ENRAGED when boss_hp<=ENRAGE_HP and boss_hp!=0.
  - CHASE/ENRAGED→DEAD when boss_hp==0. This takes priority over ENRAGED, so an HP drop straight to 0 goes directly to DEAD.
  - Any state→IDLE when game_active=0. This re-inits x, y, HP and iframe to their reset values on the same edge.
  - DEAD is sticky while game_active=1.
- Damage:
  - Accepted only when hit=1, phase is CHASE or ENRAGED, and iframe==0.
  - Update: boss_hp <= (boss_hp > hit_dmg) ? boss_hp-hit_dmg : 0 (saturating, no wrap). hit_dmg is zero-extended to HP_W.
  - On accept, iframe <= IFRAMES. iframe decrements by 1 on each frame_tick while nonzero.
  - Hit coinciding with frame_tick: load wins over decrement.
  - Hits during iframe>0, IDLE, or DEAD are dropped. hit_dmg=0 is accepted and still loads iframe.
  - boss_hp reflects a hit one cycle after the pulse.
- Movement, on frame_tick only, in CHASE/ENRAGED:
  - Step s = SPEED (CHASE) or 2*SPEED (ENRAGED).
  - If boss_x+DEADZONE < char_x: boss_x <= min(boss_x+s, X_MAX-BOSS_LNG).
  - Else if boss_x > char_x+DEADZONE: boss_x <= max(boss_x-s, X_MIN), with no underflow.
  - Otherwise boss_x holds.
  - All comparisons and sums use 13-bit intermediates.
  - IDLE/DEAD: position holds.
- defeated = (phase==DEAD), registered.

Optional Feature:
BOSS_JUMP_EN
- Defined: in ENRAGED, the boss jumps every 90 frames while grounded.
  - Launch: signed vy <= -12. Each frame_tick: boss_y += vy, vy += 1.
  - Landing: when boss_y+vy >= GROUND_Y, boss_y <= GROUND_Y and vy <= 0.
  - Leaving ENRAGED mid-air: vy <= 0 and boss_y <= GROUND_Y the next frame_tick.
- Undefined: boss_y is constant GROUND_Y after reset, and no vy register is built.

Decomposition:
- boss_pkg holds:
  - typedef enum logic [1:0] boss_phase_t: IDLE=0, CHASE=1, ENRAGED=2, DEAD=3
  - BOSS_HGT=95, BOSS_LNG=106
  - screen-width constants
- One sub-module, frame_tick_gen, parametrised by CLK_HZ and FRAME_HZ (clk, rst, tick out). It is reused by player and projectile blocks.

Test Plan:
- Frame tick: CLK_HZ=600, FRAME_HZ=60, release reset → frame_tick pulses exactly every 10 cycles, 1 cycle wide.
- Phase entry and enrage: game_active=1, hit with hit_dmg=15 on four occasions spaced >IFRAMES frames apart from MAX_HP=100:
  - phase goes IDLE→CHASE after 1 cycle.
  - HP reads 85, 70, 55, 40.
  - phase=ENRAGED 1 cycle after HP reaches 40.
- Invincibility: hit dmg=5 twice, 3 frames apart (IFRAMES=8) → HP 100→95 only. A third hit 9 frames after the first → 90.
- Saturation: HP=3, hit dmg=10 → HP=0, phase=DEAD, defeated=1. Further hits → HP stays 0. game_active=0 → IDLE, HP=100, x=START_X.
- Movement: char_x=100, boss_x=700, CHASE → x decreases 2 per frame.
  - ENRAGED → 4 per frame.
  - Reaches 104 and holds; no oscillation inside DEADZONE.
  - char_x=1023 → x clamps at 917.
- Reset mid-game: assert rst=0 for 1 cycle during ENRAGED with iframe>0 → all outputs at reset values next cycle, and the next hit is accepted immediately.
